// File: rtl/async_operator_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : async_operator_fifo
//  Description : Per-operand input FIFOs feeding one arithmetic operator whose
//                registered result is fanned out to OUTPUT_SIZE consumers with
//                independent one-cycle acknowledges.
//                Optional statistics (fire_count, overflow) are built only when
//                ASYNC_OPERATOR_FIFO_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_operator_fifo #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    INPUT_SIZE  = 2,
  parameter int    OUTPUT_SIZE = 1,
  parameter int    DEPTH       = 4,
  parameter string OP          = "add",
  parameter int    IMMEDIATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout
`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
  ,
  output logic [31:0]                      fire_count,
  output logic                             overflow
`endif
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH + 1);

  // Operation encoding; an OP that does not fit INPUT_SIZE collapses to 0.
  localparam int C_OP_NONE = 0;
  localparam int C_OP_PASS = 1;
  localparam int C_OP_ADDI = 2;
  localparam int C_OP_SUBI = 3;
  localparam int C_OP_MULI = 4;
  localparam int C_OP_ADD  = 5;
  localparam int C_OP_SUB  = 6;
  localparam int C_OP_MUL  = 7;

  localparam int C_OP_CODE =
    (INPUT_SIZE == 1) ?
      (((OP == "reg") || (OP == "in") || (OP == "out")) ? C_OP_PASS :
       (OP == "addi") ? C_OP_ADDI :
       (OP == "subi") ? C_OP_SUBI :
       (OP == "muli") ? C_OP_MULI : C_OP_NONE) :
    ((INPUT_SIZE == 2) || (INPUT_SIZE == 3)) ?
      ((OP == "add") ? C_OP_ADD :
       (OP == "sub") ? C_OP_SUB :
       (OP == "mul") ? C_OP_MUL : C_OP_NONE) :
    C_OP_NONE;

  localparam logic [DATA_WIDTH-1:0] C_IMM = DATA_WIDTH'(IMMEDIATE);

  // Missing operands act as the identity of the selected operator.
  localparam logic [DATA_WIDTH-1:0] C_FILL = DATA_WIDTH'((C_OP_CODE == C_OP_MUL) ? 1 : 0);

  logic [DATA_WIDTH-1:0]  w_head [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  w_opnd [3];
  logic [INPUT_SIZE-1:0]  w_nonempty;
  logic [OUTPUT_SIZE-1:0] r_pending;
  logic [OUTPUT_SIZE-1:0] w_serve;
  logic [DATA_WIDTH-1:0]  w_result;
  logic                   w_fire;
  logic                   r_started;

  // A consumer is served once per result; the ~ack_r term spaces acks apart.
  assign w_serve = r_pending & req_r & ~ack_r;
  // Fire once every operand is present and no consumer still owes an ack.
  assign w_fire  = (&w_nonempty) && ((r_pending & ~w_serve) == '0);

`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
  logic [INPUT_SIZE-1:0] w_drop;
`endif

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_fifo
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic [C_CNT_W-1:0]    w_count_next;
    logic                  w_full;
    logic                  w_push;
    logic                  r_req;

    assign w_full        = (r_count == C_CNT_W'(DEPTH));
    assign w_push        = ack_l[i] && !w_full;
    assign w_nonempty[i] = (r_count != '0);
    assign w_head[i]     = r_mem[r_rd_ptr];
    assign req_l[i]      = r_req;
`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
    assign w_drop[i]     = ack_l[i] && w_full;
`endif

    // Occupancy after this cycle's push/pop; a simultaneous pair cancels.
    always_comb begin
      w_count_next = r_count;
      if (w_push && !w_fire) begin
        w_count_next = r_count + 1'b1;
      end else if (!w_push && w_fire) begin
        w_count_next = r_count - 1'b1;
      end
    end

    // Storage, wrapping pointers and the registered upstream request.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_mem[k] <= '0;
        end
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_req    <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= din[DATA_WIDTH*i +: DATA_WIDTH];
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_fire) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= w_count_next;
        // Ask only with two free slots left, so a late ack still fits.
        r_req   <= r_started && !ack_l[i] && (w_count_next <= C_CNT_W'(DEPTH - 2));
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_opnd
    if (k < INPUT_SIZE) begin : g_real
      assign w_opnd[k] = w_head[k];
    end else begin : g_fill
      assign w_opnd[k] = C_FILL;
    end
  end

  // Operator datapath; results are naturally truncated to DATA_WIDTH.
  always_comb begin
    w_result = '0;
    case (C_OP_CODE)
      C_OP_PASS: w_result = w_opnd[0];
      C_OP_ADDI: w_result = w_opnd[0] + C_IMM;
      C_OP_SUBI: w_result = w_opnd[0] - C_IMM;
      C_OP_MULI: w_result = w_opnd[0] * C_IMM;
      C_OP_ADD:  w_result = w_opnd[0] + w_opnd[1] + w_opnd[2];
      C_OP_SUB:  w_result = w_opnd[0] - w_opnd[1] - w_opnd[2];
      C_OP_MUL:  w_result = w_opnd[0] * w_opnd[1] * w_opnd[2];
      default:   w_result = '0;
    endcase
  end

  // Result register, pending mask and consumer acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_started <= 1'b0;
      r_pending <= '0;
      ack_r     <= '0;
      dout      <= '0;
    end else begin
      r_started <= 1'b1;
      ack_r     <= w_serve;
      if (w_fire) begin
        r_pending <= '1;
        dout      <= w_result;
      end else begin
        r_pending <= r_pending & ~w_serve;
      end
    end
  end

`ifdef ASYNC_OPERATOR_FIFO_STATS_EN
  // Fire counter (wraps) and sticky flag for data dropped at a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (w_fire) begin
        fire_count <= fire_count + 32'd1;
      end
      if (|w_drop) begin
        overflow <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/async_operator_fifo.md
ASYNC_OPERATOR_FIFO -- requirements
Module: async_operator_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter INPUT_SIZE, default 2: operand channels, legal 1..3.
REQ-003 SHALL have parameter OUTPUT_SIZE, default 1: fan-out consumers, legal 1..8.
REQ-004 SHALL have parameter DEPTH, default 4: per-input FIFO entries, power of two, >=2.
REQ-005 SHALL have parameter OP, default "add": operation string.
REQ-006 SHALL have parameter IMMEDIATE, default 0: constant for immediate ops.
REQ-007 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port req_l, output, INPUT_SIZE: per-input request to upstream.
REQ-010 SHALL have port ack_l, input, INPUT_SIZE: per-input one-cycle upstream ack, data valid same cycle.
REQ-011 SHALL have port din, input, DATA_WIDTH*INPUT_SIZE: operand i in bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-012 SHALL have port req_r, input, OUTPUT_SIZE: per-consumer request.
REQ-013 SHALL have port ack_r, output, OUTPUT_SIZE: per-consumer one-cycle ack.
REQ-014 SHALL have port dout, output, DATA_WIDTH: registered result.

Function
REQ-015 Each input i SHALL own a DEPTH-entry FIFO with occupancy 0..DEPTH; ack_l[i] high pushes din slice i at that edge.
REQ-016 req_l[i] SHALL be registered, asserted only when the FIFO has >=2 free entries after this cycle's push/pop, and low the cycle after any ack_l[i].
REQ-017 ack_l[i] while FIFO full SHALL drop the data and leave FIFO contents unchanged.
REQ-018 Fire SHALL occur when every FIFO is non-empty and the pending mask is zero (or clears this cycle); fire pops one entry per FIFO, loads dout, sets pending to all ones.
REQ-019 Latency: operand pushed at edge t SHALL appear on dout at edge t+1 if fire conditions hold; earliest ack_r at edge t+2.
REQ-020 For each j: if pending[j] & req_r[j] & ~ack_r[j], ack_r[j] SHALL pulse high one cycle and pending[j] clear; otherwise ack_r[j] low.
REQ-021 Consumers SHALL be served independently; each receives exactly one ack per result; dout SHALL hold until pending is zero.
REQ-022 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-023 Ops, INPUT_SIZE=1: "reg"/"in"/"out" pass-through, "addi"/"subi"/"muli" with IMMEDIATE; INPUT_SIZE 2/3: "add", "sub" (op0-op1-op2), "mul"; unlisted OP SHALL give dout 0.
REQ-024 Arithmetic SHALL be modulo 2^DATA_WIDTH (low DATA_WIDTH bits kept).

Reset
REQ-025 rst low SHALL immediately clear FIFOs, pending, req_l, ack_r, dout to 0, independent of clk.
REQ-026 Reset mid-operation SHALL discard buffered operands and any unacked result; req_l SHALL first rise at the second rising edge after rst release.

Configuration
REQ-027 With macro ASYNC_OPERATOR_FIFO_STATS_EN defined, SHALL add output fire_count (32 bits, reset 0) incrementing per fire, wrapping at 2^32, and output overflow (1 bit, sticky, reset 0) set by REQ-017 events.
REQ-028 Without ASYNC_OPERATOR_FIFO_STATS_EN, those ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 OP="add", INPUT_SIZE=2: push 5 on in0, 7 on in1, req_r=1 -> dout=12, ack_r pulses once.
REQ-030 OP="sub", INPUT_SIZE=3: operands 10,3,2 -> dout=5; operands 0,1,0 -> dout=0xFFFFFFFF.
REQ-031 OUTPUT_SIZE=2, req_r[0]=1, req_r[1]=0 for 10 cycles -> one ack_r[0], dout held, no new fire; raise req_r[1] -> one ack_r[1], then next fire.
REQ-032 DEPTH=4, req_r=0, upstream always acks in0/in1 -> req_l drops with occupancy <=4, no overflow; release req_r -> results in push order.
REQ-033 Force ack_l[0] while in0 FIFO full -> data dropped; with STATS_EN overflow=1; fire_count equals accepted result count.
REQ-034 Assert rst low mid-stream with 3 buffered operands -> all outputs 0 asynchronously; after release, first result uses only post-reset data.
